// File: rtl/sfq_xort_resp_checker.sv
// sfq_xort_resp_checker
//
// Receive-side response checker for a clocked SFQ XOR (XORT) cell. Each of the
// four SFQ lines is toggle-encoded, so one level change on a line is one pulse.
// The checker decodes the pulses, keeps the a/b flags for the current SFQ clock
// period, works out whether the cell should fire, and checks that the out pulse
// lands inside the [MIN_DLY, MAX_DLY] window after the SFQ clock pulse.
//
// Ports:
//   clk         system oversampling clock, rising edge
//   rst_n       asynchronous active-low reset
//   sfq_a       toggle-encoded a pulses
//   sfq_b       toggle-encoded b pulses
//   sfq_clk     toggle-encoded XORT clock pulses
//   sfq_out     toggle-encoded XORT output pulses
//   check_en    1 = checking active
//   busy        1 while a response window is open (state WAIT)
//   err_pulse   one-cycle strobe, one cycle after an error is detected
//   err_code    last error: 0 none, 1 missing, 2 spurious, 3 early
//   match_count correctly timed out pulses, saturating
//   err_count   errors, saturating
//
// Handshake: there is no backpressure. err_pulse is a single-cycle valid with
// err_code as its payload; match_count advancing by one is the match event.
module sfq_xort_resp_checker #(
    parameter int MIN_DLY = 2,
    parameter int MAX_DLY = 8,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sfq_a,
    input  logic             sfq_b,
    input  logic             sfq_clk,
    input  logic             sfq_out,
    input  logic             check_en,
    output logic             busy,
    output logic             err_pulse,
    output logic [1:0]       err_code,
    output logic [CNT_W-1:0] match_count,
    output logic [CNT_W-1:0] err_count
);

    localparam int WIN_W = $clog2(MAX_DLY + 1);
    localparam logic [WIN_W-1:0] MIN_V = WIN_W'(MIN_DLY);
    localparam logic [WIN_W-1:0] MAX_V = WIN_W'(MAX_DLY);

    localparam logic [1:0] ERR_MISSING  = 2'd1;
    localparam logic [1:0] ERR_SPURIOUS = 2'd2;
    localparam logic [1:0] ERR_EARLY    = 2'd3;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    state_t           state, state_nxt;
    logic [WIN_W-1:0] win_cnt, win_cnt_nxt;
    logic             prev_a, prev_b, prev_clk, prev_out;
    logic             st_a, st_b;
    logic             pulse_a, pulse_b, pulse_clk, pulse_out;
    logic             expected;
    logic             err_det;
    logic [1:0]       err_det_code;
    logic             match_det;

    assign pulse_a   = sfq_a   ^ prev_a;
    assign pulse_b   = sfq_b   ^ prev_b;
    assign pulse_clk = sfq_clk ^ prev_clk;
    assign pulse_out = sfq_out ^ prev_out;

    // Flags as they stood before this cycle's clock pulse.
    assign expected = st_a ^ st_b;

    assign busy = (state == WAIT);

    always_comb begin
        state_nxt    = state;
        win_cnt_nxt  = win_cnt;
        err_det      = 1'b0;
        err_det_code = 2'd0;
        match_det    = 1'b0;
        if (!check_en) begin
            state_nxt   = IDLE;
            win_cnt_nxt = '0;
        end else begin
            // Close or advance the pending window first; an out pulse arriving
            // together with a new clock pulse still belongs to the old window.
            if (state == WAIT) begin
                if (pulse_out) begin
                    if (win_cnt < MIN_V) begin
                        err_det      = 1'b1;
                        err_det_code = ERR_EARLY;
                    end else begin
                        match_det = 1'b1;
                    end
                    state_nxt   = IDLE;
                    win_cnt_nxt = '0;
                end else if (win_cnt == MAX_V || pulse_clk) begin
                    err_det      = 1'b1;
                    err_det_code = ERR_MISSING;
                    state_nxt    = IDLE;
                    win_cnt_nxt  = '0;
                end else begin
                    win_cnt_nxt = win_cnt + 1'b1;
                end
            end else if (pulse_out) begin
                err_det      = 1'b1;
                err_det_code = ERR_SPURIOUS;
            end
            // A clock pulse is then evaluated as if from IDLE.
            if (pulse_clk && expected) begin
                state_nxt   = WAIT;
                win_cnt_nxt = WIN_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            win_cnt <= '0;
        end else begin
            state   <= state_nxt;
            win_cnt <= win_cnt_nxt;
        end
    end

    // Edge history runs regardless of check_en so enabling never sees a
    // stale level difference as a pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_a   <= 1'b0;
            prev_b   <= 1'b0;
            prev_clk <= 1'b0;
            prev_out <= 1'b0;
        end else begin
            prev_a   <= sfq_a;
            prev_b   <= sfq_b;
            prev_clk <= sfq_clk;
            prev_out <= sfq_out;
        end
    end

    // A clock pulse clears the flags; an a/b pulse in the same cycle lands in
    // the next period, hence the clear-then-set form.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_a <= 1'b0;
            st_b <= 1'b0;
        end else if (!check_en) begin
            st_a <= 1'b0;
            st_b <= 1'b0;
        end else if (pulse_clk) begin
            st_a <= pulse_a;
            st_b <= pulse_b;
        end else begin
            st_a <= st_a | pulse_a;
            st_b <= st_b | pulse_b;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_pulse   <= 1'b0;
            err_code    <= 2'd0;
            match_count <= '0;
            err_count   <= '0;
        end else begin
            err_pulse <= err_det;
            if (err_det) begin
                err_code <= err_det_code;
                if (err_count != '1) begin
                    err_count <= err_count + 1'b1;
                end
            end
            if (match_det && match_count != '1) begin
                match_count <= match_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sfq_xort_resp_checker.sv
// Directed bench for sfq_xort_resp_checker. Stimulus pushes each expected
// event (cycle, kind) into exp_q when it toggles the causing line; the monitor
// pops and compares whenever err_pulse fires or match_count advances.
// Kind encoding: 3'b100 = match, 3'b0cc = error with code cc.
module tb_sfq_xort_resp_checker;

  localparam int CNT_W = 16;
  localparam logic [2:0] K_MATCH = 3'b100;
  localparam logic [2:0] K_MISS  = 3'b001;
  localparam logic [2:0] K_SPUR  = 3'b010;
  localparam logic [2:0] K_EARLY = 3'b011;

  logic             clk;
  logic             rst_n;
  logic             sfq_a, sfq_b, sfq_clk, sfq_out;
  logic             check_en;
  logic             busy;
  logic             err_pulse;
  logic [1:0]       err_code;
  logic [CNT_W-1:0] match_count;
  logic [CNT_W-1:0] err_count;

  logic [31:0]      cyc;
  logic [34:0]      exp_q[$];
  int               n_checks;
  int               n_fail;
  logic [CNT_W-1:0] last_match;
  logic             got;
  logic [2:0]       got_kind;
  logic [34:0]      exp_e;

  sfq_xort_resp_checker #(.MIN_DLY(2), .MAX_DLY(8), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .sfq_a(sfq_a), .sfq_b(sfq_b), .sfq_clk(sfq_clk), .sfq_out(sfq_out),
    .check_en(check_en), .busy(busy), .err_pulse(err_pulse), .err_code(err_code),
    .match_count(match_count), .err_count(err_count)
  );

  // clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = '0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  // driver tasks: each call consumes one cycle; inputs change at the negedge
  task automatic tog(input logic ta, input logic tb, input logic tc, input logic to);
    @(negedge clk);
    sfq_a   = sfq_a ^ ta;
    sfq_b   = sfq_b ^ tb;
    sfq_clk = sfq_clk ^ tc;
    sfq_out = sfq_out ^ to;
  endtask

  task automatic idle(input int n);
    repeat (n) tog(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // expected event observed dly negedges after the current drive cycle
  task automatic push_exp(input int dly, input logic [2:0] kind);
    exp_q.push_back({cyc + 32'(dly), kind});
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d (cyc %0d)", name, act, req, cyc);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    sfq_a = 1'b0; sfq_b = 1'b0; sfq_clk = 1'b0; sfq_out = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      got = 1'b0;
      got_kind = 3'b000;
      if (err_pulse === 1'b1) begin
        got = 1'b1;
        got_kind = {1'b0, err_code};
      end else if (match_count !== last_match) begin
        got = 1'b1;
        got_kind = K_MATCH;
      end
      if (got) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_event: got kind %0d at cyc %0d, required no event", got_kind, cyc);
        end else begin
          exp_e = exp_q.pop_front();
          if (exp_e !== {cyc, got_kind}) begin
            n_fail++;
            $display("FAIL event: got kind %0d at cyc %0d, required kind %0d at cyc %0d",
                     got_kind, cyc, exp_e[2:0], exp_e[34:3]);
          end
        end
      end
    end
    last_match = match_count;
  end

  initial begin
    n_checks = 0;
    n_fail = 0;
    last_match = '0;
    rst_n = 1'b0;
    check_en = 1'b1;
    sfq_a = 1'b0; sfq_b = 1'b0; sfq_clk = 1'b0; sfq_out = 1'b0;
    do_reset();

    // reset defaults, then 20 quiet cycles (monitor flags any stray strobe)
    idle(1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_err_code", 32'(err_code), 0);
    chk("rst_match_count", 32'(match_count), 0);
    chk("rst_err_count", 32'(err_count), 0);
    idle(20);

    // single-input match, delay 4
    tog(1, 0, 0, 0);
    idle(2);
    tog(0, 0, 1, 0);
    idle(1); chk("match_busy_d1", 32'(busy), 1);
    idle(1); chk("match_busy_d2", 32'(busy), 1);
    idle(1); chk("match_busy_d3", 32'(busy), 1);
    tog(0, 0, 0, 1); push_exp(1, K_MATCH);
    chk("match_busy_d4", 32'(busy), 1);
    idle(1); chk("match_busy_after", 32'(busy), 0);
    idle(2);
    chk("match_count_1", 32'(match_count), 1);
    chk("match_err_count_0", 32'(err_count), 0);
    idle(10);

    // a and b cancel: no window; a later out is spurious
    tog(1, 0, 0, 0);
    idle(1);
    tog(0, 1, 0, 0);
    idle(1);
    tog(0, 0, 1, 0);
    idle(1); chk("cancel_busy", 32'(busy), 0);
    idle(2);
    tog(0, 0, 0, 1); push_exp(1, K_SPUR);
    idle(3);
    chk("spur_err_code", 32'(err_code), 2);
    chk("spur_err_count", 32'(err_count), 1);
    idle(10);

    // early: delay 1
    tog(1, 0, 0, 0);
    tog(0, 0, 1, 0);
    tog(0, 0, 0, 1); push_exp(1, K_EARLY);
    idle(3);
    chk("early_err_code", 32'(err_code), 3);
    idle(10);

    // missing: strobe at clk + MAX_DLY + 1
    tog(1, 0, 0, 0);
    tog(0, 0, 1, 0); push_exp(9, K_MISS);
    idle(12);
    chk("miss_err_code", 32'(err_code), 1);
    chk("miss_err_count", 32'(err_count), 3);

    // delay 8, the last cycle of the window
    tog(1, 0, 0, 0);
    tog(0, 0, 1, 0);
    idle(7);
    tog(0, 0, 0, 1); push_exp(1, K_MATCH);
    idle(3);
    chk("dly8_match_count", 32'(match_count), 2);
    idle(10);

    // a and clock in the same cycle: a belongs to the next period
    tog(1, 0, 1, 0);
    idle(1); chk("samecyc_busy", 32'(busy), 0);
    idle(1);
    tog(0, 0, 1, 0);
    idle(2);
    tog(0, 0, 0, 1); push_exp(1, K_MATCH);
    idle(3);
    chk("samecyc_match_count", 32'(match_count), 3);
    idle(10);

    // new clock during an open window ends it as missing
    tog(1, 0, 0, 0);
    tog(0, 0, 1, 0);
    idle(2);
    tog(0, 0, 1, 0); push_exp(1, K_MISS);
    idle(1); chk("reclk_busy", 32'(busy), 0);
    idle(2);
    chk("reclk_err_count", 32'(err_count), 4);
    chk("reclk_err_code", 32'(err_code), 1);
    idle(10);

    // check_en low: pulses tracked, nothing checked, counters frozen
    @(negedge clk); check_en = 1'b0;
    tog(1, 0, 0, 0);
    tog(0, 0, 1, 0);
    idle(1); chk("dis_busy", 32'(busy), 0);
    tog(0, 0, 0, 1);
    idle(3);
    chk("dis_err_count", 32'(err_count), 4);
    chk("dis_match_count", 32'(match_count), 3);
    @(negedge clk); check_en = 1'b1;
    idle(3);
    tog(0, 1, 0, 0);
    tog(0, 0, 1, 0);
    idle(1);
    tog(0, 0, 0, 1); push_exp(1, K_MATCH);
    idle(3);
    chk("en_match_count", 32'(match_count), 4);
    chk("en_err_count", 32'(err_count), 4);
    idle(10);

    // reset while a window is open at counter 4
    tog(1, 0, 0, 0);
    tog(0, 0, 1, 0);
    idle(4);
    chk("midrst_busy_before", 32'(busy), 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_err_pulse", 32'(err_pulse), 0);
    chk("midrst_err_code", 32'(err_code), 0);
    chk("midrst_match_count", 32'(match_count), 0);
    chk("midrst_err_count", 32'(err_count), 0);
    sfq_a = 1'b0; sfq_b = 1'b0; sfq_clk = 1'b0; sfq_out = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    idle(3);
    tog(0, 0, 0, 1); push_exp(1, K_SPUR);
    idle(3);
    chk("post_rst_err_count", 32'(err_count), 1);
    chk("post_rst_err_code", 32'(err_code), 2);
    chk("post_rst_match_count", 32'(match_count), 0);
    idle(5);

    // every expected event must have been seen
    while (exp_q.size() != 0) begin
      exp_e = exp_q.pop_front();
      n_checks++;
      n_fail++;
      $display("FAIL missed_event: got none, required kind %0d at cyc %0d", exp_e[2:0], exp_e[34:3]);
    end

    // final report
    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
